// File: rtl/tmr_apb_mc.sv
// Multi-channel APB timer: ch_n channels sharing one prescaler, each in one-shot, periodic,
// PWM or input-capture mode. Capture logic is present only when TMR_APB_MC_CAP_EN is defined.
module tmr_apb_mc #(
  parameter int unsigned tmr_w = 16,
  parameter int unsigned ch_n  = 4,
  parameter int unsigned psc_w = 8
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic [7:0]      paddr,
  output logic [31:0]     prdata,
  input  logic [31:0]     pwdata,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  output logic            pready,
  output logic            pslverr,
  output logic            irq,
  input  logic [ch_n-1:0] tmr_in,
  output logic [ch_n-1:0] tmr_out
);

  localparam int unsigned IrqW = 2 * ch_n;
  localparam logic [1:0] ModeOneShot  = 2'b00;
  localparam logic [1:0] ModePeriodic = 2'b01;
  localparam logic [1:0] ModePwm      = 2'b10;
  localparam logic [1:0] ModeCapture  = 2'b11;

`ifdef TMR_APB_MC_CAP_EN
  localparam logic [IrqW-1:0] IrqMask = '1;
`else
  // Capture status/enable bits (odd positions) do not exist in this build.
  localparam logic [IrqW-1:0] IrqMask = {ch_n{2'b01}};
`endif

  logic            we;
  logic [3:0]      blk;
  logic [1:0]      wsel;
  logic            glb_sel;
  logic            mapped;
  logic            any_en;
  logic            tick;
  logic [IrqW-1:0] w1c;

  logic [IrqW-1:0]  irq_st_q, irq_st_d;
  logic [IrqW-1:0]  irq_en_q, irq_en_d;
  logic [IrqW-1:0]  irq_set;
  logic [psc_w-1:0] psc_q, psc_d;
  logic [psc_w-1:0] psc_cnt_q, psc_cnt_d;
  logic [ch_n-1:0]  en_q, en_d;
  logic [ch_n-1:0]  out_q, out_d;
  logic [ch_n-1:0]  wrap;
  logic [ch_n-1:0]  ch_we;
  logic [ch_n-1:0]  cap_edge;
  logic [1:0]       mode_q [ch_n];
  logic [1:0]       mode_d [ch_n];
  logic [1:0]       mode_eff [ch_n];
  logic [tmr_w-1:0] cnt_q [ch_n];
  logic [tmr_w-1:0] cnt_d [ch_n];
  logic [tmr_w-1:0] top_q [ch_n];
  logic [tmr_w-1:0] top_d [ch_n];
  logic [tmr_w-1:0] cmp_q [ch_n];
  logic [tmr_w-1:0] cmp_d [ch_n];
  logic             irq_q;
  logic             unused_bits;

  assign we      = psel & pwrite & penable;
  assign blk     = paddr[7:4];
  assign wsel    = paddr[3:2];
  assign glb_sel = (blk == 4'd0);
  assign mapped  = (32'(blk) <= ch_n);
  assign pready  = penable;
  assign pslverr = psel & penable & ~mapped;
  assign irq     = irq_q;
  assign tmr_out = out_q;

  assign any_en = |en_q;
  assign tick   = any_en && (psc_cnt_q == psc_q);
  assign w1c    = (we && glb_sel && (wsel == 2'd0)) ? pwdata[IrqW-1:0] : '0;

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef TMR_APB_MC_CAP_EN
    return m;
`else
    return (m == ModeCapture) ? ModePeriodic : m;
`endif
  endfunction

`ifdef TMR_APB_MC_CAP_EN
  logic [ch_n-1:0] sync0_q, sync1_q, prev_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      prev_q  <= '0;
    end else begin
      sync0_q <= tmr_in;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
    end
  end

  assign cap_edge    = sync1_q & ~prev_q;
  assign unused_bits = ^{paddr[1:0], pwdata};
`else
  assign cap_edge    = '0;
  assign unused_bits = ^{paddr[1:0], pwdata, tmr_in};
`endif

  always_comb begin
    for (int unsigned c = 0; c < ch_n; c++) begin
      mode_eff[c] = eff_mode(mode_q[c]);
      ch_we[c]    = we && (32'(blk) == c + 1);
    end
  end

  always_comb begin
    psc_d     = psc_q;
    psc_cnt_d = psc_cnt_q;
    irq_en_d  = irq_en_q;
    irq_set   = '0;
    en_d      = en_q;
    out_d     = out_q;
    wrap      = '0;
    for (int unsigned c = 0; c < ch_n; c++) begin
      mode_d[c] = mode_q[c];
      cnt_d[c]  = cnt_q[c];
      top_d[c]  = top_q[c];
      cmp_d[c]  = cmp_q[c];
    end

    // Prescaler parks at 0 whenever no channel is enabled.
    if (!any_en || tick) begin
      psc_cnt_d = '0;
    end else begin
      psc_cnt_d = psc_cnt_q + psc_w'(1);
    end
    if (we && glb_sel && (wsel == 2'd2)) begin
      psc_d     = pwdata[psc_w-1:0];
      psc_cnt_d = '0;
    end
    if (we && glb_sel && (wsel == 2'd1)) begin
      irq_en_d = pwdata[IrqW-1:0] & IrqMask;
    end

    for (int unsigned c = 0; c < ch_n; c++) begin
      if (tick && en_q[c]) begin
        if (cnt_q[c] == top_q[c]) begin
          wrap[c]      = 1'b1;
          cnt_d[c]     = '0;
          irq_set[2*c] = 1'b1;
          if (mode_eff[c] == ModeOneShot) begin
            en_d[c] = 1'b0;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + tmr_w'(1);
        end
      end

      // Capture takes CNT before this cycle's increment.
      if (cap_edge[c] && en_q[c] && (mode_eff[c] == ModeCapture)) begin
        cmp_d[c]         = cnt_q[c];
        irq_set[2*c + 1] = 1'b1;
      end

      // Software writes override same-cycle hardware updates.
      if (ch_we[c]) begin
        unique case (wsel)
          2'd0: begin
            en_d[c]   = pwdata[0];
            mode_d[c] = pwdata[2:1];
          end
          2'd1:    cnt_d[c] = pwdata[tmr_w-1:0];
          2'd2:    top_d[c] = pwdata[tmr_w-1:0];
          default: cmp_d[c] = pwdata[tmr_w-1:0];
        endcase
      end

      if (en_q[c]) begin
        unique case (mode_eff[c])
          ModeOneShot, ModePeriodic: begin
            if (wrap[c]) begin
              out_d[c] = ~out_q[c];
            end
          end
          ModePwm: begin
            if (tick) begin
              out_d[c] = (cnt_d[c] < cmp_d[c]);
            end
          end
          default: out_d[c] = 1'b0;
        endcase
      end
    end
  end

  // Hardware set wins over a same-cycle write-1-to-clear.
  assign irq_st_d = (irq_st_q & ~w1c) | (irq_set & IrqMask);

  always_comb begin
    prdata = '0;
    if (glb_sel) begin
      unique case (wsel)
        2'd0:    prdata = 32'(irq_st_q);
        2'd1:    prdata = 32'(irq_en_q);
        2'd2:    prdata = 32'(psc_q);
        default: prdata = '0;
      endcase
    end
    for (int unsigned c = 0; c < ch_n; c++) begin
      if (32'(blk) == c + 1) begin
        unique case (wsel)
          2'd0:    prdata = {29'd0, mode_q[c], en_q[c]};
          2'd1:    prdata = 32'(cnt_q[c]);
          2'd2:    prdata = 32'(top_q[c]);
          default: prdata = 32'(cmp_q[c]);
        endcase
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      irq_st_q  <= '0;
      irq_en_q  <= '0;
      psc_q     <= '0;
      psc_cnt_q <= '0;
      en_q      <= '0;
      out_q     <= '0;
      irq_q     <= 1'b0;
      for (int unsigned c = 0; c < ch_n; c++) begin
        mode_q[c] <= '0;
        cnt_q[c]  <= '0;
        top_q[c]  <= '0;
        cmp_q[c]  <= '0;
      end
    end else begin
      irq_st_q  <= irq_st_d;
      irq_en_q  <= irq_en_d;
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
      en_q      <= en_d;
      out_q     <= out_d;
      irq_q     <= |(irq_st_q & irq_en_q);
      for (int unsigned c = 0; c < ch_n; c++) begin
        mode_q[c] <= mode_d[c];
        cnt_q[c]  <= cnt_d[c];
        top_q[c]  <= top_d[c];
        cmp_q[c]  <= cmp_d[c];
      end
    end
  end

endmodule

// File: tb/tb_tmr_apb_mc.sv
// Self-checking bench for tmr_apb_mc; expected values come from closed-form counts of
// prescaler ticks and wraps. Capture checks are built when TMR_APB_MC_CAP_EN is defined.
module tb_tmr_apb_mc;

  localparam int TmrW = 16;
  localparam int ChN  = 4;
  localparam int PscW = 8;

  logic           pclk = 1'b0;
  logic           preset = 1'b1;
  logic [7:0]     paddr = '0;
  logic [31:0]    prdata;
  logic [31:0]    pwdata = '0;
  logic           psel = 1'b0;
  logic           penable = 1'b0;
  logic           pwrite = 1'b0;
  logic           pready;
  logic           pslverr;
  logic           irq;
  logic [ChN-1:0] tmr_in = '0;
  logic [ChN-1:0] tmr_out;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  tmr_apb_mc #(
    .tmr_w(TmrW),
    .ch_n (ChN),
    .psc_w(PscW)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .paddr  (paddr),
    .prdata (prdata),
    .pwdata (pwdata),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pready (pready),
    .pslverr(pslverr),
    .irq    (irq),
    .tmr_in (tmr_in),
    .tmr_out(tmr_out)
  );

  function automatic logic [7:0] ch_addr(input int c, input int r);
    return 8'(16 + 16 * c + 4 * r);
  endfunction

  // All tasks are entered and left just after a falling pclk edge.
  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; tmr_in = '0;
    preset = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
  endtask

  // The write lands on the second rising edge after the call.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err,
                          output logic rdy);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d = prdata; err = pslverr; rdy = pready;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    paddr = a;
    #1;
    d = prdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic err, rdy;
    do_reset();
    for (int a = 0; a < 16 + 16 * ChN; a += 4) begin
      peek(8'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg addr=%02h got %08h expected 00000000", a, d);
      end
    end
    checks++;
    if (irq !== 1'b0 || tmr_out !== '0) begin
      errors++;
      $display("FAIL reset_out irq=%b tmr_out=%b expected 0/0", irq, tmr_out);
    end
    apb_read(8'h08, d, err, rdy);
    checks++;
    if (err !== 1'b0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mapped_read pslverr=%b pready=%b expected 0/1", err, rdy);
    end
  endtask

  task automatic test_periodic();
    for (int it = 0; it < 3; it++) begin
      int c, psc, top, nmax, ticks, wraps;
      logic [ChN-1:0] exp_out;
      logic [31:0] d, exp_st;
      do_reset();
      c    = $urandom_range(ChN - 1, 0);
      psc  = $urandom_range(3, 0);
      top  = $urandom_range(5, 0);
      nmax = 2 * (psc + 1) * (top + 1) + 3;
      wraps = 0;
      apb_write(8'h08, 32'(psc));
      apb_write(ch_addr(c, 2), 32'(top));
      apb_write(ch_addr(c, 0), 32'h3);
      paddr = ch_addr(c, 1);
      for (int n = 1; n <= nmax; n++) begin
        @(negedge pclk);
        #1;
        ticks   = n / (psc + 1);
        wraps   = ticks / (top + 1);
        exp_out = '0;
        exp_out[c] = wraps[0];
        checks++;
        if (prdata !== 32'(ticks % (top + 1)) || tmr_out !== exp_out) begin
          errors++;
          $display("FAIL periodic ch=%0d psc=%0d top=%0d n=%0d cnt=%0d out=%b expected %0d/%b",
                   c, psc, top, n, prdata, tmr_out, ticks % (top + 1), exp_out);
        end
      end
      peek(8'h00, d);
      exp_st = 32'(1) << (2 * c);
      checks++;
      if (d !== exp_st || irq !== 1'b0) begin
        errors++;
        $display("FAIL periodic_irq_st got %08h irq=%b expected %08h irq=0", d, irq, exp_st);
      end
    end
  endtask

  task automatic test_oneshot();
    int c, top;
    logic [31:0] d;
    logic [ChN-1:0] exp_out;
    do_reset();
    c   = (ChN > 1) ? 1 : 0;
    top = $urandom_range(4, 0);
    apb_write(8'h04, 32'(1) << (2 * c));
    apb_write(8'h08, 32'd0);
    apb_write(ch_addr(c, 2), 32'(top));
    apb_write(ch_addr(c, 0), 32'h1);
    paddr = ch_addr(c, 1);
    for (int n = 1; n <= top + 6; n++) begin
      @(negedge pclk);
      #1;
      exp_out = '0;
      exp_out[c] = (n >= top + 1);
      checks++;
      if (prdata !== ((n <= top) ? 32'(n) : 32'd0) || tmr_out !== exp_out ||
          irq !== (n >= top + 2)) begin
        errors++;
        $display("FAIL oneshot top=%0d n=%0d cnt=%0d out=%b irq=%b", top, n, prdata, tmr_out,
                 irq);
      end
    end
    peek(ch_addr(c, 0), d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_en_clear ctrl=%08h expected 00000000", d);
    end
    apb_write(8'h00, 32'(1) << (2 * c));
    peek(8'h00, d);
    checks++;
    if (d !== 32'd0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_w1c st=%08h irq=%b expected 00000000 irq=1 (one-cycle lag)", d, irq);
    end
    @(negedge pclk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_drop irq=%b expected 0", irq);
    end
  endtask

  task automatic test_pwm();
    for (int v = 0; v < 3; v++) begin
      int top, cmp, cnt, highs;
      logic exp_o;
      do_reset();
      top = $urandom_range(9, 3);
      if (v == 0) cmp = 0;
      else if (v == 1) cmp = $urandom_range(top, 1);
      else cmp = top + 1 + $urandom_range(3, 0);
      highs = 0;
      apb_write(8'h08, 32'd0);
      apb_write(ch_addr(0, 2), 32'(top));
      apb_write(ch_addr(0, 3), 32'(cmp));
      apb_write(ch_addr(0, 0), 32'h5);
      paddr = ch_addr(0, 1);
      for (int n = 1; n <= 2 * (top + 1) + 1; n++) begin
        @(negedge pclk);
        #1;
        cnt   = n % (top + 1);
        exp_o = (cnt < cmp);
        if (n <= top + 1 && tmr_out[0]) highs++;
        checks++;
        if (prdata !== 32'(cnt) || tmr_out[0] !== exp_o) begin
          errors++;
          $display("FAIL pwm top=%0d cmp=%0d n=%0d cnt=%0d out=%b expected %0d/%b", top, cmp, n,
                   prdata, tmr_out[0], cnt, exp_o);
        end
      end
      checks++;
      if (highs != ((cmp < top + 1) ? cmp : top + 1)) begin
        errors++;
        $display("FAIL pwm_duty top=%0d cmp=%0d high_cycles=%0d expected %0d", top, cmp, highs,
                 (cmp < top + 1) ? cmp : top + 1);
      end
    end
  endtask

`ifdef TMR_APB_MC_CAP_EN
  task automatic test_capture();
    int c, k;
    logic [31:0] d;
    do_reset();
    c = (ChN > 2) ? 2 : 0;
    k = $urandom_range(10, 3);
    apb_write(8'h08, 32'd0);
    apb_write(ch_addr(c, 2), 32'd255);
    apb_write(ch_addr(c, 0), 32'h7);
    repeat (k) @(negedge pclk);
    tmr_in[c] = 1'b1;
    repeat (2) @(negedge pclk);
    peek(ch_addr(c, 3), d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL capture_early cmp=%0d expected 0", d);
    end
    // Two synchroniser stages plus the edge detector: CNT is sampled two cycles after the rise.
    @(negedge pclk);
    peek(ch_addr(c, 3), d);
    checks++;
    if (d !== 32'(k + 2)) begin
      errors++;
      $display("FAIL capture_value cmp=%0d expected %0d", d, k + 2);
    end
    peek(8'h00, d);
    checks++;
    if (d !== (32'(1) << (2 * c + 1))) begin
      errors++;
      $display("FAIL capture_irq_st got %08h expected %08h", d, 32'(1) << (2 * c + 1));
    end
    peek(ch_addr(c, 1), d);
    checks++;
    if (d !== 32'(k + 3) || tmr_out !== '0) begin
      errors++;
      $display("FAIL capture_cnt cnt=%0d out=%b expected %0d/0", d, tmr_out, k + 3);
    end
  endtask
`else
  task automatic test_cap_disabled();
    int c, top;
    logic [31:0] d, mask;
    mask = '0;
    for (int i = 0; i < ChN; i++) mask[2*i] = 1'b1;
    do_reset();
    c   = ChN - 1;
    top = $urandom_range(4, 1);
    tmr_in = '1;
    apb_write(8'h04, 32'hFFFF_FFFF);
    peek(8'h04, d);
    checks++;
    if (d !== mask) begin
      errors++;
      $display("FAIL nocap_irq_en got %08h expected %08h", d, mask);
    end
    apb_write(8'h08, 32'd0);
    apb_write(ch_addr(c, 2), 32'(top));
    apb_write(ch_addr(c, 0), 32'h7);
    paddr = ch_addr(c, 1);
    for (int n = 1; n <= 2 * (top + 1) + 1; n++) begin
      @(negedge pclk);
      #1;
      checks++;
      if (prdata !== 32'(n % (top + 1)) || tmr_out[c] !== ((n / (top + 1)) % 2 == 1)) begin
        errors++;
        $display("FAIL nocap_periodic n=%0d cnt=%0d out=%b expected %0d/%0d", n, prdata,
                 tmr_out[c], n % (top + 1), (n / (top + 1)) % 2);
      end
    end
    peek(ch_addr(c, 3), d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL nocap_cmp got %0d expected 0", d);
    end
    peek(8'h00, d);
    checks++;
    if (d !== (32'(1) << (2 * c))) begin
      errors++;
      $display("FAIL nocap_irq_st got %08h expected %08h", d, 32'(1) << (2 * c));
    end
  endtask
`endif

  task automatic test_w1c_and_decode();
    int t;
    logic [31:0] d;
    logic err, rdy;
    do_reset();
    t = $urandom_range(6, 3);
    apb_write(8'h08, 32'd0);
    apb_write(ch_addr(0, 2), 32'(t));
    apb_write(ch_addr(0, 0), 32'h3);
    repeat (2 * t) @(negedge pclk);
    apb_write(8'h00, 32'h1);  // lands on the second wrap
    peek(8'h00, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL w1c_collision st=%08h expected 00000001", d);
    end
    apb_write(8'h00, 32'h1);  // lands between wraps
    peek(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL w1c_clear st=%08h expected 00000000", d);
    end
    apb_read(8'hFC, d, err, rdy);
    checks++;
    if (d !== 32'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_fc prdata=%08h pslverr=%b expected 00000000/1", d, err);
    end
    if (16 + 16 * ChN < 256) begin
      apb_write(8'(16 + 16 * ChN), 32'hFFFF_FFFF);
      apb_read(8'(16 + 16 * ChN), d, err, rdy);
      checks++;
      if (d !== 32'd0 || err !== 1'b1) begin
        errors++;
        $display("FAIL unmapped_edge prdata=%08h pslverr=%b expected 00000000/1", d, err);
      end
    end
    apb_read(ch_addr(ChN - 1, 3), d, err, rdy);
    checks++;
    if (d !== 32'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL last_channel prdata=%08h pslverr=%b expected 00000000/0", d, err);
    end
  endtask

  task automatic test_sw_priority();
    int v;
    logic [31:0] d;
    do_reset();
    v = $urandom_range(150, 10);
    apb_write(8'h08, 32'd0);
    apb_write(ch_addr(0, 2), 32'd200);
    apb_write(ch_addr(0, 0), 32'h3);
    repeat (3) @(negedge pclk);
    apb_write(ch_addr(0, 1), 32'(v));
    peek(ch_addr(0, 1), d);
    checks++;
    if (d !== 32'(v)) begin
      errors++;
      $display("FAIL sw_cnt_write cnt=%0d expected %0d", d, v);
    end
    @(negedge pclk);
    peek(ch_addr(0, 1), d);
    checks++;
    if (d !== 32'(v + 1)) begin
      errors++;
      $display("FAIL sw_cnt_resume cnt=%0d expected %0d", d, v + 1);
    end
    apb_write(ch_addr(0, 0), 32'h5);
    peek(ch_addr(0, 1), d);
    checks++;
    if (d !== 32'(v + 3)) begin
      errors++;
      $display("FAIL mode_keeps_cnt cnt=%0d expected %0d", d, v + 3);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    apb_write(8'h04, 32'h1);
    apb_write(8'h08, 32'd0);
    apb_write(ch_addr(0, 2), 32'd2);
    apb_write(ch_addr(0, 0), 32'h3);
    repeat (5) @(negedge pclk);
    peek(ch_addr(0, 1), d);
    checks++;
    if (d !== 32'd2 || tmr_out[0] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset cnt=%0d out=%b irq=%b expected 2/1/1", d, tmr_out[0], irq);
    end
    #1;
    preset = 1'b1;
    peek(ch_addr(0, 1), d);
    checks++;
    if (d !== 32'd0 || tmr_out !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset cnt=%0d out=%b irq=%b expected 0/0/0", d, tmr_out, irq);
    end
    @(negedge pclk);
    preset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pwm();
`ifdef TMR_APB_MC_CAP_EN
    test_capture();
`else
    test_cap_disabled();
`endif
    test_w1c_and_decode();
    test_sw_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
